// File: rtl/interp_chain_sequencer_pkg.sv
// Shared types for the interpolator chain sequencer: state encoding, idle sample value,
// tick/flush counter widths and small saturating helpers.
package interp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_PRIME,
        ST_RUN,
        ST_DRAIN
    } seq_state_t;

    localparam logic [7:0] MIDSCALE_DEFAULT = 8'h80;
    localparam int         TICK_W           = 8;
    localparam int         FLUSH_W          = 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [TICK_W-1:0] tick_inc(input logic [TICK_W-1:0] v);
        return (v == {TICK_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/interp_chain_sequencer_pulse_gen.sv
// Three cascaded mod-DIV counters producing one-clk stage enables at clk/DIV, clk/DIV^2, clk/DIV^3.
// Latency: first 4M8 pulse DIV clk after run rises, first 48k pulse DIV^3 clk after.
// Backpressure: none; run low or clear holds all counters at zero with pulses off.
module gated_decade_pulse_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic run,
    input  logic clear,
    output logic pulse_48k,
    output logic pulse_480k,
    output logic pulse_4M8
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

    logic [CW-1:0] c0, c1, c2;
    logic          c0_wrap, c1_wrap, c2_wrap, c0_pre;

    assign c0_wrap = (c0 == LAST);
    assign c1_wrap = (c1 == LAST);
    assign c2_wrap = (c2 == LAST);
    assign c0_pre  = (c0 == PRE);

    // Pulses are registered one cycle ahead of the wrap so they land on the DIV-th clk of each period.
    always_ff @(posedge clk) begin
        if (clear || !run) begin
            c0         <= '0;
            c1         <= '0;
            c2         <= '0;
            pulse_4M8  <= 1'b0;
            pulse_480k <= 1'b0;
            pulse_48k  <= 1'b0;
        end else begin
            c0 <= c0_wrap ? '0 : c0 + 1'b1;
            if (c0_wrap) begin
                c1 <= c1_wrap ? '0 : c1 + 1'b1;
            end
            if (c0_wrap && c1_wrap) begin
                c2 <= c2_wrap ? '0 : c2 + 1'b1;
            end
            pulse_4M8  <= c0_pre;
            pulse_480k <= c0_pre && c1_wrap;
            pulse_48k  <= c0_pre && c1_wrap && c2_wrap;
        end
    end

endmodule

// File: rtl/interp_chain_sequencer.sv
// Sequences the 3-stage 10x interpolator chain: stage enables, x0/x1 sample pair, reset/mute/drain.
// Latency: one sample accepted per 48k tick; x0/x1 update the clk after the pulse_48k cycle.
// Backpressure: in_ready high every PRIME cycle and only on the pulse_48k cycle in RUN; a missing sample is an underrun.
module interp_chain_sequencer
    import interp_seq_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               DIV          = 10,
    parameter int               FLUSH_CYCLES = 16,
    parameter int               WARMUP_TICKS = 3,
    parameter int               DRAIN_TICKS  = 4,
    parameter logic [WIDTH-1:0] MIDSCALE     = WIDTH'(MIDSCALE_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] signal_x0,
    output logic [WIDTH-1:0] signal_x1,
    output logic             pulse_48k,
    output logic             pulse_480k,
    output logic             pulse_4M8,
    output logic             chain_rst,
    output logic             out_mute,
    output logic             underrun,
    output logic [15:0]      underrun_count
);

    seq_state_t         state;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [TICK_W-1:0]  tick_cnt;
    logic               gen_run;

    assign gen_run  = (state == ST_RUN) || (state == ST_DRAIN);
    assign in_ready = (state == ST_PRIME) || ((state == ST_RUN) && pulse_48k);

    gated_decade_pulse_gen #(
        .DIV (DIV)
    ) u_pulse_gen (
        .clk        (clk),
        .run        (gen_run),
        .clear      (rst),
        .pulse_48k  (pulse_48k),
        .pulse_480k (pulse_480k),
        .pulse_4M8  (pulse_4M8)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            flush_cnt      <= '0;
            tick_cnt       <= '0;
            signal_x0      <= MIDSCALE;
            signal_x1      <= MIDSCALE;
            chain_rst      <= 1'b1;
            out_mute       <= 1'b1;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    chain_rst <= 1'b1;
                    out_mute  <= 1'b1;
                    if (enable) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end
                end

                ST_FLUSH: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (int'(flush_cnt) + 1 >= FLUSH_CYCLES) begin
                        state     <= ST_PRIME;
                        chain_rst <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end

                // A transfer wins over a simultaneous enable drop: the sample is already committed.
                ST_PRIME: begin
                    if (in_valid) begin
                        signal_x0 <= in_data;
                        signal_x1 <= in_data;
                        tick_cnt  <= '0;
                        state     <= ST_RUN;
                    end else if (!enable) begin
                        state     <= ST_IDLE;
                        chain_rst <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (pulse_48k) begin
                        signal_x0 <= signal_x1;
                        if (in_valid) begin
                            signal_x1 <= in_data;
                        end else begin
                            underrun       <= 1'b1;
                            underrun_count <= sat_inc16(underrun_count);
                        end
                        tick_cnt <= tick_inc(tick_cnt);
                        if (int'(tick_cnt) + 1 >= WARMUP_TICKS) begin
                            out_mute <= 1'b0;
                        end
                        if (!enable) begin
                            state    <= ST_DRAIN;
                            tick_cnt <= '0;
                            out_mute <= 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    out_mute <= 1'b1;
                    if (pulse_48k) begin
                        signal_x0 <= signal_x1;
                        signal_x1 <= MIDSCALE;
                        tick_cnt  <= tick_inc(tick_cnt);
                        if (int'(tick_cnt) + 1 >= DRAIN_TICKS) begin
                            state     <= ST_IDLE;
                            chain_rst <= 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    chain_rst <= 1'b1;
                    out_mute  <= 1'b1;
                end
            endcase
        end
    end

endmodule
